// File: rtl/serial_subtractor_pkg.sv
// Shared controller FSM state encodings for the serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor from gate primitives: d = x - y - bin, bout set on underflow.
// Combinational, zero latency; no flow control.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    wire xy_diff;
    wire x_n;
    wire xy_same;
    wire brw_xy;
    wire brw_in;

    xor g_xy   (xy_diff, x, y);
    xor g_d    (d, xy_diff, bin);
    not g_xn   (x_n, x);
    and g_bxy  (brw_xy, x_n, y);
    not g_same (xy_same, xy_diff);
    and g_bin  (brw_in, xy_same, bin);
    or  g_bout (bout, brw_xy, brw_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first through one full-subtractor cell; done WIDTH+1 cycles after start.
// start is only honoured when not busy; the result is held until the next operation completes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        brw   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc <= {cell_d, acc[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    brw <= cell_bout;
                    cnt <= cnt + 1'b1;
                    // Last bit: publish straight from the cell so the result lands with done.
                    if (cnt == LAST) begin
                        diff     <= {cell_d, acc[WIDTH-1:1]};
                        borrow   <= cell_bout;
                        overflow <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized traffic against a timeline model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted start schedules a result W edges later; anything else just waits.
    bit           m_valid = 1'b0;
    int           m_left  = 0;
    int           m_r     = 0;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic [W-1:0] m_diff  = '0;
    logic         m_bor   = 1'b0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] pa      = '0;
    logic [W-1:0] pb      = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_diff  = '0;
            m_bor   = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_diff = W'(pa - pb);
                m_bor  = (pa < pb);
                m_r    = int'($signed(pa)) - int'($signed(pb));
                m_ovf  = (m_r > (2 ** (W - 1)) - 1) || (m_r < -(2 ** (W - 1)));
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                pa     = a;
                pb     = b;
                m_left = W;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_result", 32'({diff, borrow, overflow}), 32'({m_diff, m_bor, m_ovf}));
        end
    end

    // Runs one operation from a negedge; optionally pulses a stray start at cycle noise_at.
    task automatic op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ed, input logic eb, input logic eo,
                      input int noise_at, input logic [W-1:0] na, input logic [W-1:0] nb);
        int n;
        a = ia;
        b = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = '0;
        b = '0;
        n = 1;
        while (!done && n < 4 * W) begin
            if (n == noise_at) begin
                start = 1'b1;
                a = na;
                b = nb;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
        chk({tag, "_model"}, 32'({m_diff, m_bor, m_ovf}), 32'({ed, eb, eo}));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int t1;
        int seen;
        logic [W-1:0] d1;
        logic bo1;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'({diff, borrow, overflow}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("basic", 8'h2D, 8'h12, 8'h1B, 1'b0, 1'b0, -1, '0, '0);
        op("under", 8'h12, 8'h2D, 8'hE5, 1'b1, 1'b0, -1, '0, '0);
        op("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, -1, '0, '0);
        op("ovf_neg", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, -1, '0, '0);
        op("ovf_pos", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, -1, '0, '0);
        op("ignored", 8'h2D, 8'h12, 8'h1B, 1'b0, 1'b0, 4, 8'hFF, 8'h01);

        // Back-to-back: start held across the DONE cycle.
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        @(negedge clk);
        a = 8'h03;
        b = 8'h05;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        t1 = n;
        d1 = diff;
        bo1 = borrow;
        @(negedge clk);
        start = 1'b0;
        n++;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_at", 32'(t1), 32'(W + 1));
        chk("b2b_first", 32'({d1, bo1}), 32'({8'h02, 1'b0}));
        chk("b2b_gap", 32'(n - t1), 32'(W + 1));
        chk("b2b_second", 32'({diff, borrow}), 32'({8'hFE, 1'b1}));
        @(negedge clk);

        // Reset during SHIFT wipes the held result and cancels the pending done.
        a = 8'h12;
        b = 8'h2D;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'({diff, borrow, overflow}), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        op("after_rst", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, -1, '0, '0);

        // Random traffic: stray starts, operand churn and occasional resets.
        repeat (1500) begin
            rst = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (2 * W) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
